// File: rtl/pwm_bright_ctrl.sv
// pwm_bright_ctrl: multi-channel LED brightness controller.
// Four raw push-buttons are synchronised and debounced internally. They step
// the selected channel's duty (saturating), pick the next channel, and toggle
// that channel between steady and breathe mode. All channels share one
// free-running PWM counter. Duty changes are latched only at period boundaries.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   btn_plus   raw button, raise selected channel duty by STEP
//   btn_minus  raw button, lower selected channel duty by STEP
//   btn_sel    raw button, advance selected channel (wraps)
//   btn_mode   raw button, toggle selected channel steady/breathe
//   led        registered PWM outputs, one per channel
//   cur_ch     currently selected channel
//   cur_duty   programmed duty of the selected channel
//   cur_mode   mode of the selected channel (0 steady, 1 breathe)
module pwm_bright_ctrl #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 8,
  parameter int STEP       = 16,
  parameter int RESET_DUTY = 128,
  parameter int DEB_CYCLES = 1000,
  parameter int FADE_DIV   = 4096,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_plus,
  input  logic             btn_minus,
  input  logic             btn_sel,
  input  logic             btn_mode,
  output logic [NCH-1:0]   led,
  output logic [CW-1:0]    cur_ch,
  output logic [WIDTH-1:0] cur_duty,
  output logic             cur_mode
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int B_PLUS  = 0;
  localparam int B_MINUS = 1;
  localparam int B_SEL   = 2;
  localparam int B_MODE  = 3;
  localparam logic [WIDTH:0]   MAXV  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   STEPV = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] TOP   = '1;

  typedef enum logic {FADE_UP, FADE_DOWN} fade_dir_t;

  // ---------------- debouncers ----------------
  logic [3:0]    raw;
  logic [3:0]    sync1, sync2;
  logic [3:0]    acc, lock, pulse;
  logic [DW-1:0] dcnt [4];

  assign raw = {btn_mode, btn_sel, btn_minus, btn_plus};

  // Synchroniser is deliberately left out of reset so a button held through
  // reset is still seen as pressed immediately afterwards.
  always_ff @(posedge clk) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  // After reset each debouncer is locked: it behaves as if the button were
  // already accepted high, so a held button must be released (accepted low)
  // before a new press can produce a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      lock  <= '1;
      pulse <= '0;
      for (int unsigned b = 0; b < 4; b++) dcnt[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        pulse[b] <= 1'b0;
        if (sync2[b] == (acc[b] | lock[b])) begin
          dcnt[b] <= '0;
        end else if (dcnt[b] == DW'(DEB_CYCLES - 1)) begin
          dcnt[b]  <= '0;
          acc[b]   <= sync2[b];
          lock[b]  <= 1'b0;
          pulse[b] <= sync2[b];
        end else begin
          dcnt[b] <= dcnt[b] + 1'b1;
        end
      end
    end
  end

  // ---------------- channel registers ----------------
  logic [WIDTH-1:0] duty [NCH];
  logic [NCH-1:0]   mode;
  logic [CW-1:0]    ch;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] inc, dec;

  // Borrow into bit WIDTH marks an underflow (STEP < 2^WIDTH).
  always_comb begin
    sum = {1'b0, duty[ch]} + STEPV;
    dif = {1'b0, duty[ch]} - STEPV;
    inc = (sum > MAXV) ? MAXV[WIDTH-1:0] : sum[WIDTH-1:0];
    dec = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) duty[i] <= WIDTH'(RESET_DUTY);
      mode <= '0;
      ch   <= '0;
    end else begin
      if (pulse[B_PLUS] && !pulse[B_MINUS])      duty[ch] <= inc;
      else if (pulse[B_MINUS] && !pulse[B_PLUS]) duty[ch] <= dec;
      if (pulse[B_MODE]) mode[ch] <= ~mode[ch];
      if (pulse[B_SEL])  ch <= (ch == CW'(NCH - 1)) ? '0 : ch + 1'b1;
    end
  end

  assign cur_ch   = ch;
  assign cur_duty = duty[ch];
  assign cur_mode = mode[ch];

  // ---------------- breathe level ----------------
  logic [FW-1:0]    fdiv;
  logic             tick;
  logic [WIDTH-1:0] level, level_nxt;
  fade_dir_t        dir, dir_nxt;

  assign tick = (fdiv == FW'(FADE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      fdiv  <= '0;
      level <= '0;
      dir   <= FADE_UP;
    end else begin
      fdiv  <= tick ? '0 : fdiv + 1'b1;
      level <= level_nxt;
      dir   <= dir_nxt;
    end
  end

  always_comb begin
    level_nxt = level;
    dir_nxt   = dir;
    if (tick) begin
      unique case (dir)
        FADE_UP: begin
          level_nxt = level + 1'b1;
          if (level_nxt == TOP) dir_nxt = FADE_DOWN;
        end
        FADE_DOWN: begin
          level_nxt = level - 1'b1;
          if (level_nxt == '0) dir_nxt = FADE_UP;
        end
        default: ;
      endcase
    end
  end

  // ---------------- PWM ----------------
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] eff    [NCH];
  logic [WIDTH-1:0] shadow [NCH];

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      eff[i] = duty[i];
      if (mode[i] && (level < duty[i])) eff[i] = level;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      led <= '0;
      for (int unsigned i = 0; i < NCH; i++) shadow[i] <= WIDTH'(RESET_DUTY);
    end else begin
      cnt <= cnt + 1'b1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cnt == TOP) shadow[i] <= eff[i];
        led[i] <= (cnt < shadow[i]);
      end
    end
  end

endmodule
